// File: rtl/accum_arbiter.sv
// accum_arbiter: round-robin owner selection for one shared burst accumulator with a valid/ready result port.
// Optional macro ACCUM_SAT_EN: saturate at 2^AW-1 instead of wrapping and export result_sat.
module accum_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 26,
  parameter int LW   = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LW-1:0]   req_len,
  input  logic [NREQ*DW-1:0]   in_data,
  input  logic [NREQ-1:0]      in_valid,
  output logic [NREQ-1:0]      in_ready,
  output logic [NREQ-1:0]      grant,
  output logic [AW-1:0]        result,
  output logic [IDW-1:0]       result_id,
  output logic                 result_valid,
  input  logic                 result_ready
`ifdef ACCUM_SAT_EN
  ,
  output logic                 result_sat
`endif
);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  owner;
  logic [LW-1:0]   len;
  logic [LW-1:0]   cnt;
  logic [AW-1:0]   accum;
  logic [AW-1:0]   accum_next;

  logic [NREQ-1:0] masked;
  logic            pick_found;
  logic [IDW-1:0]  pick_id;
  logic [LW-1:0]   pick_len;

  logic [NREQ-1:0] owner_onehot;
  logic [DW-1:0]   owner_data;
  logic            owner_valid;
  logic            burst_open;
  logic            take;

  // Requests at or above rr_ptr win first; otherwise fall back to the lowest set bit (wrap-around).
  always_comb begin
    masked     = req & ~((NREQ'(1) << rr_ptr) - NREQ'(1));
    pick_found = |req;
    pick_id    = '0;
    pick_len   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) pick_id = IDW'(i);
    end
    if (|masked) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (masked[i]) pick_id = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == IDW'(i)) pick_len = req_len[i*LW +: LW];
    end
  end

  always_comb begin
    owner_onehot = '0;
    owner_data   = '0;
    owner_valid  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDW'(i)) begin
        owner_onehot[i] = 1'b1;
        owner_data      = in_data[i*DW +: DW];
        owner_valid     = in_valid[i];
      end
    end
  end

  // in_ready drops as soon as the last sample is in, one cycle before leaving ACCUM.
  assign burst_open = (state == ACCUM) && (cnt != len);
  assign take       = burst_open && owner_valid;

`ifdef ACCUM_SAT_EN
  logic [AW:0] sum_wide;
  logic        sat_hit;
  logic        sat_flag;

  assign sum_wide   = {1'b0, accum} + {1'b0, AW'(owner_data)};
  assign sat_hit    = sum_wide[AW];
  assign accum_next = sat_hit ? {AW{1'b1}} : sum_wide[AW-1:0];
  assign result_sat = sat_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (state == CLEAR) begin
      sat_flag <= 1'b0;
    end else if (take && sat_hit) begin
      sat_flag <= 1'b1;
    end
  end
`else
  assign accum_next = accum + AW'(owner_data);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    grant        = '0;
    in_ready     = '0;
    result       = accum;
    result_id    = owner;
    result_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) state_next = CLEAR;
      end
      CLEAR: begin
        grant      = owner_onehot;
        state_next = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        grant = owner_onehot;
        if (burst_open) in_ready = owner_onehot;
        if (cnt == len) state_next = DONE;
      end
      DONE: begin
        grant        = owner_onehot;
        result_valid = 1'b1;
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Owner and length are captured only at arbitration, so later req/req_len changes cannot disturb a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      owner  <= '0;
      len    <= '0;
      cnt    <= '0;
      accum  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            owner <= pick_id;
            len   <= pick_len;
          end
        end
        CLEAR: begin
          accum <= '0;
          cnt   <= '0;
        end
        ACCUM: begin
          if (take) begin
            accum <= accum_next;
            cnt   <= cnt + LW'(1);
          end
        end
        DONE: begin
          if (result_ready) begin
            rr_ptr <= (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_arbiter.sv
// Randomized self-checking bench for accum_arbiter against a transaction-level round-robin/burst-sum model.
// Build with ACCUM_SAT_EN defined to exercise the saturating variant.
module tb_accum_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int AW   = 17;
  localparam int LW   = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*LW-1:0] req_len = '0;
  logic [NREQ*DW-1:0] in_data = '0;
  logic [NREQ-1:0]   in_valid = '0;
  logic [NREQ-1:0]   in_ready;
  logic [NREQ-1:0]   grant;
  logic [AW-1:0]     result;
  logic [IDW-1:0]    result_id;
  logic              result_valid;
  logic              result_ready = 1'b0;
`ifdef ACCUM_SAT_EN
  logic              result_sat;
`endif

  int passCount = 0;
  int checkCount = 0;
  int modelPtr = 0;

  accum_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .LW(LW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_len(req_len),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .grant(grant),
    .result(result),
    .result_id(result_id),
    .result_valid(result_valid),
    .result_ready(result_ready)
`ifdef ACCUM_SAT_EN
    ,
    .result_sat(result_sat)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // First requester at or after the pointer, scanning modulo NREQ.
  function automatic int pickWinner(input logic [NREQ-1:0] vec, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (ptr + k) % NREQ;
      if (((vec >> c) & NREQ'(1)) != '0) return c;
    end
    return -1;
  endfunction

  // One complete arbitration + burst + result transaction, checked against the model.
  task automatic applyStimulus(input logic [NREQ-1:0] vec, input logic [NREQ*LW-1:0] lenVec,
                               input int dataMode, input bit alwaysValid,
                               input int stallCycles, input bit dropReq);
    int winner, expLen, accepted, waitCyc;
    longint total, expResult, maxVal, s;
    longint sampleQ[$];
    bit expSat, leak, unstable;
    logic [NREQ-1:0] own, validVec;
    logic [NREQ*DW-1:0] dataVec;
    logic [DW-1:0] d;
    logic [AW-1:0] held;
    bit v;

    winner = pickWinner(vec, modelPtr);
    expLen = int'((lenVec >> (winner * LW)) & (NREQ*LW)'(15));
    own    = NREQ'(1) << winner;
    maxVal = (longint'(1) << AW) - 1;
    total  = 0;
    sampleQ.delete();
    for (int k = 0; k < expLen; k++) begin
      case (dataMode)
        1:       s = 10 * (winner + 1);
        2:       s = 65535;
        3:       s = 5 + 2 * k;
        default: s = longint'($urandom_range(0, 65535));
      endcase
      sampleQ.push_back(s);
      total += s;
    end
`ifdef ACCUM_SAT_EN
    expSat    = (total > maxVal);
    expResult = expSat ? maxVal : total;
`else
    expSat    = 1'b0;
    expResult = total % (longint'(1) << AW);
`endif

    req     = vec;
    req_len = lenVec;
    @(negedge clk);
    checkOutput("arbGrant", grant, own);
    if (dropReq) req = '0;
    req_len = (NREQ*LW)'($urandom_range(0, 65535));

    accepted = 0;
    waitCyc  = 0;
    leak     = 1'b0;
    while (!result_valid && waitCyc < 200) begin
      dataVec  = '0;
      validVec = '0;
      for (int i = 0; i < NREQ; i++) begin
        d = DW'($urandom_range(0, 65535));
        v = 1'($urandom_range(0, 1));
        if (i == winner) begin
          if (alwaysValid) v = 1'b1;
          if (sampleQ.size() > 0) d = DW'(sampleQ[0]);
        end
        dataVec  = dataVec | ((NREQ*DW)'(d) << (i * DW));
        validVec = validVec | (NREQ'(v) << i);
      end
      in_data  = dataVec;
      in_valid = validVec;
      if ((in_ready & ~own) != '0 || grant != own) leak = 1'b1;
      if ((in_ready & own) != '0 && (validVec & own) != '0) begin
        accepted++;
        if (sampleQ.size() > 0) void'(sampleQ.pop_front());
      end
      @(negedge clk);
      waitCyc++;
    end
    in_valid = '0;

    checkOutput("resultValid", result_valid, 1);
    checkOutput("acceptedCount", accepted, expLen);
    checkOutput("inReadyLeak", leak, 0);
    if (alwaysValid && expLen > 0) checkOutput("latency", waitCyc, expLen + 2);
    checkOutput("result", result, expResult);
    checkOutput("resultId", result_id, winner);
`ifdef ACCUM_SAT_EN
    checkOutput("resultSat", result_sat, expSat);
`endif

    held     = result;
    unstable = 1'b0;
    result_ready = 1'b0;
    for (int k = 0; k < stallCycles; k++) begin
      @(negedge clk);
      if (result != held || !result_valid || result_id != IDW'(winner) || in_ready != '0 || grant != own)
        unstable = 1'b1;
    end
    checkOutput("stallStable", unstable, 0);

    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    req = '0;
    checkOutput("releaseValid", result_valid, 0);
    checkOutput("releaseGrant", grant, 0);
    modelPtr = (winner + 1) % NREQ;
  endtask

  initial begin
    int waitCyc, accepted;
    logic [NREQ-1:0] vec;
    logic [NREQ*LW-1:0] lens;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("resetGrant", grant, 0);
    checkOutput("resetInReady", in_ready, 0);
    checkOutput("resetResult", result, 0);
    checkOutput("resetResultId", result_id, 0);
    checkOutput("resetValid", result_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, samples 5,7,9.
    applyStimulus(4'b0100, 16'h0300, 3, 1'b1, 0, 1'b0);
    // Pointer now at 3, so requester 3 beats requester 0.
    applyStimulus(4'b1001, 16'h2002, 0, 1'b1, 1, 1'b0);

    // All requesting with len=1: strict rotation 0,1,2,3,0 (pointer is back at 0).
    for (int r = 0; r < 5; r++) applyStimulus(4'b1111, 16'h1111, 1, 1'b1, 0, 1'b0);

    // Bubbles plus a stalled consumer.
    applyStimulus(4'b0010, 16'h0040, 0, 1'b0, 3, 1'b1);
    // Zero-length burst.
    applyStimulus(4'b0100, 16'h0000, 0, 1'b1, 0, 1'b0);
    // Overflow of the 17-bit sum.
    applyStimulus(4'b1000, 16'h3000, 2, 1'b1, 2, 1'b0);

    // Reset in the middle of a 5-sample burst from requester 1.
    req = 4'b0010;
    req_len = 16'h0050;
    @(negedge clk);
    in_valid = 4'b0010;
    in_data  = 64'h0000_0000_03E8_0000;
    waitCyc  = 0;
    accepted = 0;
    while (accepted < 2 && waitCyc < 20) begin
      if (in_ready[1]) accepted++;
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("midBurstAccepted", accepted, 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abortGrant", grant, 0);
    checkOutput("abortInReady", in_ready, 0);
    checkOutput("abortValid", result_valid, 0);
    checkOutput("abortResult", result, 0);
    req = '0;
    in_valid = '0;
    modelPtr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(4'b1010, 16'h2050, 0, 1'b1, 0, 1'b0);

    // Randomized transactions.
    for (int r = 0; r < 40; r++) begin
      vec  = NREQ'($urandom_range(1, 15));
      lens = (NREQ*LW)'($urandom_range(0, 65535));
      applyStimulus(vec, lens, ($urandom_range(0, 4) == 0) ? 2 : 0, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
